// File: rtl/bus_control_stream.sv
// bus_control_stream
//   Buffers full bus words in a small FIFO and serialises each one into
//   WORD_SIZE-bit words, one per accepted clock. Emission order is LSB-first
//   or MSB-first. Zero words can optionally be suppressed. Both mode inputs
//   are captured when a bus word is loaded.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-low reset
//   data_in/in_valid       bus word input, valid/ready handshake
//   in_ready               registered !full
//   lsb_first, skip_zero   mode inputs, latched per bus word at load
//   word_out/word_idx      current serialised word and its slot in the bus word
//   word_valid/word_last   output handshake valid, final word of this bus word
//   out_ready              consumer accepts the presented word
//   zero_drop              one-cycle pulse after an all-zero bus word is discarded
//   busy                   FIFO non-empty or a word is being presented
//   words_sent             16-bit wrapping count of accepted output words
//
// Serializer states
//   state  | meaning
//   S_IDLE | nothing presented; pops the FIFO head as soon as one exists
//   S_SEND | word_valid=1; advances on out_ready, reloads from FIFO on last word
//   (LOAD is not a state: it is the edge on which the head is popped)
//
// WORD_NUM must be at least 2 so that word_idx has a non-zero width.

module bus_control_stream #(
  parameter int BUS_SIZE   = 16,
  parameter int WORD_SIZE  = 4,
  parameter int WORD_NUM   = BUS_SIZE / WORD_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = $clog2(WORD_NUM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_SIZE-1:0]  data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 lsb_first,
  input  logic                 skip_zero,
  output logic [WORD_SIZE-1:0] word_out,
  output logic [IDX_W-1:0]     word_idx,
  output logic                 word_valid,
  output logic                 word_last,
  input  logic                 out_ready,
  output logic                 zero_drop,
  output logic                 busy,
  output logic [15:0]          words_sent
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [BUS_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_in_ready;

  logic                w_push;
  logic                w_pop;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [BUS_SIZE-1:0] w_head;

  assign w_push       = in_valid & r_in_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      // in_ready follows next occupancy, so a pop never lets a full FIFO
      // accept on the same edge.
      r_in_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
    end
  end

  assign in_ready = r_in_ready;

  // ---------------------------------------------------------- serializer
  state_t              r_state, w_state_nxt;
  logic [BUS_SIZE-1:0] r_shift, w_shift_nxt;
  logic [WORD_NUM-1:0] r_mask, w_mask_nxt;
  logic                r_lsb, w_lsb_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_zero_drop, w_zero_drop_nxt;
  logic [15:0]         r_words_sent;

  logic [WORD_NUM-1:0] w_head_mask;
  logic                w_head_any;
  logic [IDX_W-1:0]    w_first_idx;
  logic                w_has_next;
  logic [IDX_W-1:0]    w_next_idx;
  logic                w_valid;

  // Slots of the head word that will be presented; skipping is resolved
  // at load time so the send path only ever walks a mask.
  always_comb begin
    w_head_mask = '0;
    for (int i = 0; i < WORD_NUM; i++) begin
      w_head_mask[i] = !skip_zero || (w_head[i*WORD_SIZE +: WORD_SIZE] != '0);
    end
  end

  assign w_head_any = |w_head_mask;

  // First presented slot in emission order (last match in the loop wins).
  always_comb begin
    w_first_idx = '0;
    if (lsb_first) begin
      for (int j = WORD_NUM - 1; j >= 0; j--) begin
        if (w_head_mask[j]) w_first_idx = IDX_W'(j);
      end
    end else begin
      for (int j = 0; j < WORD_NUM; j++) begin
        if (w_head_mask[j]) w_first_idx = IDX_W'(j);
      end
    end
  end

  // Next presented slot after r_idx in the latched direction.
  always_comb begin
    w_has_next = 1'b0;
    w_next_idx = r_idx;
    if (r_lsb) begin
      for (int j = WORD_NUM - 1; j >= 0; j--) begin
        if (r_mask[j] && (j > int'(r_idx))) begin
          w_has_next = 1'b1;
          w_next_idx = IDX_W'(j);
        end
      end
    end else begin
      for (int j = 0; j < WORD_NUM; j++) begin
        if (r_mask[j] && (j < int'(r_idx))) begin
          w_has_next = 1'b1;
          w_next_idx = IDX_W'(j);
        end
      end
    end
  end

  assign w_valid = (r_state == S_SEND);
  assign w_pop   = !w_fifo_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_SEND) && out_ready && !w_has_next));

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_mask_nxt      = r_mask;
    w_lsb_nxt       = r_lsb;
    w_idx_nxt       = r_idx;
    w_zero_drop_nxt = 1'b0;
    if (w_pop) begin
      w_shift_nxt = w_head;
      w_mask_nxt  = w_head_mask;
      w_lsb_nxt   = lsb_first;
      w_idx_nxt   = w_first_idx;
      if (w_head_any) begin
        w_state_nxt = S_SEND;
      end else begin
        // All slots suppressed: discard the bus word without presenting it.
        w_state_nxt     = S_IDLE;
        w_zero_drop_nxt = 1'b1;
      end
    end else if (w_valid && out_ready) begin
      if (w_has_next) begin
        w_idx_nxt = w_next_idx;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_mask       <= '0;
      r_lsb        <= 1'b1;
      r_idx        <= '0;
      r_zero_drop  <= 1'b0;
      r_words_sent <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_mask      <= w_mask_nxt;
      r_lsb       <= w_lsb_nxt;
      r_idx       <= w_idx_nxt;
      r_zero_drop <= w_zero_drop_nxt;
      if (w_valid && out_ready) r_words_sent <= r_words_sent + 16'd1;
    end
  end

  assign word_valid = w_valid;
  assign word_out   = w_valid ? r_shift[int'(r_idx)*WORD_SIZE +: WORD_SIZE] : '0;
  assign word_idx   = w_valid ? r_idx : '0;
  assign word_last  = w_valid && !w_has_next;
  assign zero_drop  = r_zero_drop;
  assign busy       = !w_fifo_empty || w_valid;
  assign words_sent = r_words_sent;

endmodule

// File: doc/bus_control_stream.md
Name: bus_control_stream

Overview:
Parametrised successor to the fixed 16-bit/4-word bus controller. It accepts full bus words through a valid/ready handshake and buffers them in a FIFO of depth FIFO_DEPTH. It serialises each bus word into WORD_SIZE-bit words, one per clock, with a selectable order (LSB-first or MSB-first) and an optional zero-word skip mode. It sits between the bus producer and narrow word consumers, and is used by the probador/banco flow alongside its structural twin.

Parameters:
BUS_SIZE, 16, input bus width in bits; must be a multiple of WORD_SIZE.
WORD_SIZE, 4, output word width in bits.
WORD_NUM, BUS_SIZE/WORD_SIZE, words per bus word (derived; do not override).
FIFO_DEPTH, 4, bus words buffered; power of two, at least 2.
IDX_W, $clog2(WORD_NUM), width of word_idx (derived).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low; acts on the clk edge while 0
data_in  input  BUS_SIZE  bus word to enqueue
in_valid  input  1  data_in is valid
in_ready  output  1  FIFO can accept; equals !full, driven from a register
lsb_first  input  1  1 = emit word 0 (bits WORD_SIZE-1:0) first; 0 = emit word WORD_NUM-1 first
skip_zero  input  1  1 = suppress words equal to 0
word_out  output  WORD_SIZE  current serialised word
word_idx  output  IDX_W  position of word_out within its bus word
word_valid  output  1  word_out/word_idx/word_last are valid
word_last  output  1  final emitted word of the current bus word
out_ready  input  1  consumer accepts the word this cycle
zero_drop  output  1  one-cycle pulse: an all-zero bus word was discarded in skip mode
busy  output  1  FIFO non-empty or serializer active
words_sent  output  16  count of accepted output words; wraps 0xFFFF to 0

Behaviour:
- Reset (reset==0 at a clk edge) overrides everything, including mid-transfer activity.
  - Clears the FIFO, serializer and counter.
  - After reset: word_out=0, word_idx=0, word_valid=0, word_last=0, zero_drop=0, busy=0, words_sent=0, in_ready=1 from the first post-reset cycle.
- FIFO:
  - A push occurs on an edge where in_valid & in_ready.
  - in_ready derives from the registered occupancy count. When full, in_ready=0; no push-through even if a pop occurs on the same edge.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Serializer states:
  - IDLE: word_valid=0.
  - LOAD: an internal single-edge step. On the edge where the serializer is IDLE, or finishing its last word, and the FIFO is non-empty, the FIFO head is popped into the shift register. lsb_first and skip_zero are latched at this edge; mode changes mid-word have no effect.
  - SEND: word_valid=1. On an edge where out_ready=1, the serializer advances to the next non-skipped word, loads the next head (the LOAD step) if the current word was last, or returns to IDLE if the FIFO is empty.
- Latency: a bus word pushed at edge k into an empty block is popped at edge k+1. word_valid is first high in the cycle following edge k+1, i.e. 2 clocks of latency.
- Back-to-back bus words stream with no bubble between them.
- Hold rule: while word_valid=1 and out_ready=0, word_out, word_idx and word_last hold stable.
- Ordering:
  - lsb_first=1: word_idx sequence is 0,1,…,WORD_NUM-1.
  - lsb_first=0: word_idx sequence is WORD_NUM-1,…,0.
  - word_out always equals data bits [word_idx*WORD_SIZE +: WORD_SIZE].
- skip_zero=1:
  - Zero words are never presented.
  - word_last marks the last non-zero word in emission order.
  - An all-zero bus word is popped and discarded, produces no word_valid, and raises zero_drop for the cycle after the pop edge.
  - Skipping costs no extra cycles.
- words_sent increments on each edge where word_valid & out_ready.
- busy = (FIFO occupancy != 0) | word_valid.

Test Plan:
1. Reset: hold reset=0 for 2 edges during an active transfer, then release -> all outputs 0, in_ready=1, words_sent=0, and the FIFO is empty (no stale words appear).
2. Basic LSB-first: push 0xA3C5 with out_ready=1 -> word_valid appears 2 clocks later; emitted words 5,C,3,A with idx 0,1,2,3; word_last on A; words_sent=4.
3. MSB-first plus back-pressure: push 0x1234 with lsb_first=0 and hold out_ready=0 for 3 cycles -> word_out=1, idx=3 held stable; then 2,3,4 follow, with word_last on 4.
4. Skip mode: skip_zero=1, push 0x0300 then 0x0000 -> only word 3 (idx 2) is emitted, with word_last=1; the second bus word produces zero_drop for one cycle and no word_valid; words_sent=1.
5. Full/stream: push 6 words back-to-back with out_ready=0 -> in_ready drops after 4 accepted pushes (plus one more after the serializer pop). Releasing out_ready then streams all accepted words without bubbles, and words_sent=4×accepted.
6. Wrap: preload words_sent near 0xFFFE via 0x3FFF+ transfers (or force) -> increments wrap to 0x0000.
